// File: rtl/xlr8_dm_pkg.sv
// Shared definitions for the AVR data-memory front end: FSM encoding and
// RAM geometry helpers derived from the size in KB.
package xlr8_dm_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } dm_state_e;

  localparam int DM_BYTES_PER_KB = 1024;

  function automatic int dm_bytes(input int size_kb);
    return size_kb * DM_BYTES_PER_KB;
  endfunction

  function automatic int c_adr_width(input int size_kb);
    return $clog2(size_kb * DM_BYTES_PER_KB);
  endfunction

endpackage

// File: rtl/xlr8_dm_clr_seq.sv
// Clear-sweep address counter; flags the cycle that presents the last address.
module xlr8_dm_clr_seq #(
  parameter int ADR_W = 10,
  parameter int LAST  = 1023
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  output logic [15:0] adr_o,
  output logic        last_o
);

  logic [ADR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + ADR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign adr_o  = 16'(cnt_q);
  assign last_o = en_i && (cnt_q == ADR_W'(LAST));

endmodule

// File: rtl/xlr8_dm_frontend.sv
// Data-memory front end: post-reset RAM clear, then CPU-priority arbitration
// against a debug port with a starvation guard and a held debug read result.
module xlr8_dm_frontend
  import xlr8_dm_pkg::*;
#(
  parameter int         dm_size      = 1,
  parameter int         CLR_EN       = 1,
  parameter logic [7:0] CLR_VALUE    = 8'h00,
  parameter int         DBG_MAX_WAIT = 4
) (
  input  logic        cp2_i,
  input  logic        ireset_i,
  input  logic [15:0] cpu_adr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_re_i,
  input  logic        cpu_we_i,
  output logic [7:0]  cpu_din_o,
  output logic        cpu_wait_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [15:0] dbg_adr_i,
  input  logic [7:0]  dbg_wdata_i,
  output logic        dbg_ack_o,
  output logic [7:0]  dbg_rdata_o,
  output logic        dbg_rvalid_o,
  output logic        clr_done_o,
  output logic        mem_ce_o,
  output logic [15:0] mem_address_o,
  output logic [7:0]  mem_din_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_dout_i
);

  localparam int ADR_W    = c_adr_width(dm_size);
  localparam int DM_BYTES = dm_bytes(dm_size);

  dm_state_e   state_q, state_d;
  logic        clr_done_q, clr_done_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_oor_q, rd_oor_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rd_now;
  logic        run, cpu_acc, starve, dbg_grant, cpu_grant, dbg_in_range;
  logic [15:0] clr_adr;
  logic        clr_last;

  generate
    if (CLR_EN != 0) begin : g_clr
      xlr8_dm_clr_seq #(
        .ADR_W (ADR_W),
        .LAST  (DM_BYTES - 1)
      ) u_clr_seq (
        .clk_i   (cp2_i),
        .rst_n_i (ireset_i),
        .en_i    (state_q == S_CLEAR),
        .adr_o   (clr_adr),
        .last_o  (clr_last)
      );
    end else begin : g_no_clr
      assign clr_adr  = '0;
      assign clr_last = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    clr_done_d = clr_done_q;
    case (state_q)
      S_CLEAR: begin
        if (clr_last) begin
          state_d    = S_RUN;
          clr_done_d = 1'b1;
        end
      end
      S_RUN:   clr_done_d = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  // Gating on clr_done_q keeps the port idle until the first cycle truly in S_RUN.
  assign run          = (state_q == S_RUN) && clr_done_q;
  assign cpu_acc      = cpu_re_i | cpu_we_i;
  assign dbg_in_range = {1'b0, dbg_adr_i} < 17'(DM_BYTES);
  assign starve       = run && dbg_req_i && (wait_cnt_q >= 4'(DBG_MAX_WAIT));
  assign dbg_grant    = run && dbg_req_i && (!cpu_acc || starve);
  assign cpu_grant    = run && cpu_acc && !starve;

  // Reset gates the sweep strobes so the RAM sees no access while held in reset.
  always_comb begin
    mem_ce_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_address_o = '0;
    mem_din_o     = '0;
    if (state_q == S_CLEAR) begin
      mem_ce_o      = ireset_i;
      mem_we_o      = ireset_i;
      mem_address_o = clr_adr;
      mem_din_o     = CLR_VALUE;
    end else if (cpu_grant) begin
      mem_ce_o      = 1'b1;
      mem_we_o      = cpu_we_i;
      mem_address_o = cpu_adr_i;
      mem_din_o     = cpu_dout_i;
    end else if (dbg_grant) begin
      mem_ce_o      = dbg_in_range;
      mem_we_o      = dbg_we_i && dbg_in_range;
      mem_address_o = dbg_adr_i;
      mem_din_o     = dbg_wdata_i;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dbg_grant)
      wait_cnt_d = '0;
    else if (run && dbg_req_i && (wait_cnt_q != 4'hF))
      wait_cnt_d = wait_cnt_q + 4'd1;
    rd_pend_d = dbg_grant && !dbg_we_i;
    rd_oor_d  = !dbg_in_range;
    rd_now    = rd_oor_q ? 8'h00 : mem_dout_i;
    rdata_d   = rd_pend_q ? rd_now : rdata_q;
  end

  always_ff @(posedge cp2_i or negedge ireset_i) begin
    if (!ireset_i) begin
      state_q    <= (CLR_EN != 0) ? S_CLEAR : S_RUN;
      clr_done_q <= 1'b0;
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_done_q <= clr_done_d;
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_oor_q   <= rd_oor_d;
      rdata_q    <= rdata_d;
    end
  end

  assign cpu_din_o    = mem_dout_i;
  assign cpu_wait_o   = !run || starve;
  assign dbg_ack_o    = dbg_grant;
  assign dbg_rvalid_o = rd_pend_q;
  assign dbg_rdata_o  = rd_pend_q ? rd_now : rdata_q;
  assign clr_done_o   = clr_done_q;

endmodule
